muldiv_iter: RTL and testbench

- Iterative RV32M multiply/divide unit sitting directly downstream of the ALU source-A mux, in parallel with the ALU.
- Consumes the selected source-A operand and the source-B operand.
- Produces the 32-bit M-extension result after a fixed multi-cycle latency.
- The control FSM stalls the pipeline on busy and writes the result back on done.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_sign_fix.sv | 37 +++
 rtl/muldiv_iter.sv | 134 +++++++++++++
 tb/tb_muldiv_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Operation encodings, FSM states and operand-sign helpers live here.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_t;

    localparam int          MULDIV_STEPS = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_neg(logic [31:0] x);
        return |(x & INT_MIN);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection for the multiply/divide unit.
// Operates on magnitude results; divide-by-zero bypasses the quotient negation.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quot,
    input  logic [XLEN-1:0]   rem,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic              div_zero,
    output logic [XLEN-1:0]   result
);

    logic              neg;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        neg      = sign_a ^ sign_b;
        prod_fix = neg ? -prod : prod;
        quot_fix = div_zero ? XLEN'(DIV0_QUOT) : (neg ? -quot : quot);
        rem_fix  = sign_a ? -rem : rem;
        case (muldiv_op_t'(op))
            OP_MUL:                       result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quot_fix;
            default:                      result = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add / restoring divide, 34-cycle latency.
// Define MULDIV_FAST_ZERO_EN to shortcut zero-operand ops to a 2-cycle latency.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] ALU_srcA,
    input  logic [XLEN-1:0] ALU_srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_in;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0] hi_q, lo_q, b_mag_q;
    logic            sign_a_q, sign_b_q, div_zero_q;

    logic            sign_a_in, sign_b_in, fast_in, last_step;
    logic [XLEN-1:0] a_mag, b_mag, fixed;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    assign op_in     = muldiv_op_t'(func3);
    assign sign_a_in = op_a_signed(op_in) && is_neg(ALU_srcA);
    assign sign_b_in = op_b_signed(op_in) && is_neg(ALU_srcB);
    // Unsigned negation keeps |0x80000000| correct without a 33rd bit.
    assign a_mag     = sign_a_in ? -ALU_srcA : ALU_srcA;
    assign b_mag     = sign_b_in ? -ALU_srcB : ALU_srcB;
    assign last_step = (count_q == CNT_W'(MULDIV_STEPS - 1));

`ifdef MULDIV_FAST_ZERO_EN
    assign fast_in = (ALU_srcA == '0) || (ALU_srcB == '0);
`else
    assign fast_in = 1'b0;
`endif

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_q};

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = fast_in ? FIX : CALC;
            CALC:    if (last_step) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q       <= OP_MUL;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_mag_q    <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    op_q       <= op_in;
                    sign_a_q   <= sign_a_in;
                    sign_b_q   <= sign_b_in;
                    div_zero_q <= (ALU_srcB == '0);
                    b_mag_q    <= b_mag;
                    count_q    <= '0;
                    if (fast_in) begin
                        // Zero operand: product 0, remainder |A|, quotient all-ones only for /0.
                        hi_q <= op_is_div(op_in) ? a_mag : '0;
                        lo_q <= (op_is_div(op_in) && ALU_srcB == '0) ? '1 : '0;
                    end else begin
                        hi_q <= '0;
                        lo_q <= a_mag;
                    end
                end
                CALC: begin
                    count_q <= count_q + CNT_W'(1);
                    if (op_is_div(op_q)) begin
                        if (!div_diff[XLEN]) begin
                            hi_q <= div_diff[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= div_shift[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
                FIX: begin
                    result <= fixed;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op       (op_q),
        .prod     ({hi_q, lo_q}),
        .quot     (lo_q),
        .rem      (hi_q),
        .sign_a   (sign_a_q),
        .sign_b   (sign_b_q),
        .div_zero (div_zero_q),
        .result   (fixed)
    );

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: arithmetic reference model, per-cycle compare, directed and random ops.
// Honours MULDIV_FAST_ZERO_EN when computing expected latency.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    muldiv_iter dut (
        .CLK      (clk),
        .RST      (rst),
        .start    (start),
        .func3    (func3),
        .ALU_srcA (a_in),
        .ALU_srcB (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Architectural RV32M result from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Edges from the accepting edge to the done edge.
    function automatic int lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Cycle-level expectation: countdown to done, accepted only while idle.
    int          m_left;
    logic        m_done;
    logic [31:0] m_result, m_pending;

    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= 32'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= m_pending;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pending <= ref_model(func3, a_in, b_in);
                m_left    <= lat(a_in, b_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle busy", busy, m_left > 0);
            check("cycle done", done, m_done);
            check("cycle result", result, m_result);
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        func3 = f;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        func3 = 3'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_val, input int exp_cyc, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, exp_cyc);
        check({name, " result"}, result, exp_val);
        check({name, " busy at done"}, busy, 1'b0);
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_val);
        issue(f, a, b);
        wait_done(name, exp_val, lat(a, b) + 1, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        saw_done;
        logic [2:0]  f;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; func3 = 3'd0; a_in = 32'd0; b_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'd0);

        check("model MULH -1*-1", ref_model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
        check("model MULHSU -1*max", ref_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model REM -7%2", ref_model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        issue(3'd0, 32'd7, 32'd6);
        check("MUL busy cycle 1", busy, 1'b1);
        wait_done("MUL 7*6", 32'd42, 34, 1);

        run("MULH -1*-1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("REM -7%2",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("DIVU 100/7",   3'd5, 32'd100, 32'd7, 32'd14);
        run("REMU 100%7",   3'd7, 32'd100, 32'd7, 32'd2);
        run("DIVU /0",      3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run("REMU /0",      3'd7, 32'h1234, 32'd0, 32'h1234);
        run("DIV ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("REM ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // A second start mid-operation must be ignored.
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; func3 = 3'd0; a_in = 32'd5; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored start", 32'd14, 34, 11);
        // Start held in the done cycle is accepted.
        run("back-to-back REMU", 3'd7, 32'd100, 32'd7, 32'd2);

        // Reset mid-divide aborts without a done pulse.
        issue(3'd4, 32'd1000, 32'd3);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("no done after abort", saw_done, 1'b0);
        run("MUL 3*5", 3'd0, 32'd3, 32'd5, 32'd15);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run("random op", f, a, b, ref_model(f, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
